// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and parameter sanity helpers for the triggered ADC ring-buffer capture.
package adc_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // The frame must sit on a FRAME_LEN boundary so BASE_ADDR | wptr never carries.
  function automatic bit is_aligned(input int unsigned base, input int unsigned len);
    return (len != 0) && ((base % len) == 0);
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: remembers the previous accepted sample and flags a threshold
// crossing (or a forced trigger) on the current accepted sample.
module adc_trig_detect #(
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    accept,
  input  logic                    detect_en,
  input  logic                    force_trig,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  input  logic                    trig_rising,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    hit
);

  logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
  logic                    prev_ok_q, prev_ok_d;
  logic                    rise_x, fall_x, crossing;

  always_comb begin
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    if (clear) begin
      prev_d    = '0;
      prev_ok_d = 1'b0;
    end else if (accept) begin
      prev_d    = sample_data;
      prev_ok_d = 1'b1;
    end
  end

  always_comb begin
    rise_x   = (prev_q < trig_level) && (sample_data >= trig_level);
    fall_x   = (prev_q >= trig_level) && (sample_data < trig_level);
    crossing = trig_rising ? rise_x : fall_x;
    hit      = accept && detect_en && (force_trig || (prev_ok_q && crossing));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ring-buffer capture controller driving the write-only ADC port of the
// shared RAM: pre-trigger history, trigger search, post-trigger fill, then hold.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 12,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       SAMPLE_WIDTH  = 12,
  parameter int                       FRAME_LEN     = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 12'h800,
  parameter int                       PRE_TRIG      = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [SAMPLE_WIDTH-1:0]  trig_level,
  input  logic                     trig_rising,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample_data,
  output logic                     adc_wEn,
  output logic [ADDRESS_WIDTH-1:0] adc_addr,
  output logic [DATA_WIDTH-1:0]    adc_dataIn,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] trig_addr,
  output state_e                   dbg_state
);

  localparam int PTR_W    = $clog2(FRAME_LEN);
  localparam int CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int POST_LEN = FRAME_LEN - PRE_TRIG;

  generate
    if (!is_pow2(FRAME_LEN) || FRAME_LEN > (1 << ADDRESS_WIDTH)) begin : g_bad_len
      $error("adc_capture_ctrl: FRAME_LEN must be a power of two within the address space");
    end
    if (!is_aligned(int'(BASE_ADDR), FRAME_LEN)) begin : g_bad_base
      $error("adc_capture_ctrl: BASE_ADDR must be a multiple of FRAME_LEN");
    end
    if (PRE_TRIG < 1 || PRE_TRIG >= FRAME_LEN) begin : g_bad_pre
      $error("adc_capture_ctrl: PRE_TRIG out of range");
    end
    if (SAMPLE_WIDTH > DATA_WIDTH) begin : g_bad_width
      $error("adc_capture_ctrl: SAMPLE_WIDTH exceeds DATA_WIDTH");
    end
  endgenerate

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wptr_q, wptr_d;
  logic [CNT_W-1:0]         pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]         post_cnt_q, post_cnt_d;
  logic                     adc_wen_q, adc_wen_d;
  logic [ADDRESS_WIDTH-1:0] adc_addr_q, adc_addr_d;
  logic [DATA_WIDTH-1:0]    adc_data_q, adc_data_d;
  logic                     busy_q, busy_d;
  logic                     triggered_q, triggered_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] trig_addr_q, trig_addr_d;

  logic                     capturing;
  logic                     accept;
  logic                     detect_en;
  logic                     trig_hit;
  logic [ADDRESS_WIDTH-1:0] cur_addr;

  // sample_valid has no backpressure: a sample is taken in the cycle it is valid
  // or lost. An arm in the same cycle always wins and the sample is dropped.
  always_comb begin
    capturing = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    accept    = sample_valid && !arm && capturing;
    detect_en = (state_q == ST_WAIT_TRIG);
    cur_addr  = BASE_ADDR | ADDRESS_WIDTH'(wptr_q);
  end

  adc_trig_detect #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_trig_detect (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (arm),
    .accept     (accept),
    .detect_en  (detect_en),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_rising(trig_rising),
    .sample_data(sample_data),
    .hit        (trig_hit)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    adc_wen_d   = 1'b0;
    adc_addr_d  = adc_addr_q;
    adc_data_d  = adc_data_q;
    busy_d      = busy_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    trig_addr_d = trig_addr_q;

    if (arm) begin
      state_d     = ST_PRE;
      wptr_d      = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b1;
    end else if (accept) begin
      adc_wen_d  = 1'b1;
      adc_addr_d = cur_addr;
      adc_data_d = DATA_WIDTH'(sample_data);
      wptr_d     = wptr_q + PTR_W'(1);
      unique case (state_q)
        ST_PRE: begin
          pre_cnt_d = pre_cnt_q + CNT_W'(1);
          if (pre_cnt_d == CNT_W'(PRE_TRIG)) state_d = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (trig_hit) begin
            triggered_d = 1'b1;
            trig_addr_d = cur_addr;
            post_cnt_d  = CNT_W'(1);
            if (POST_LEN == 1) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
            end
          end
        end
        ST_POST: begin
          post_cnt_d = post_cnt_q + CNT_W'(1);
          if (post_cnt_d == CNT_W'(POST_LEN)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      adc_wen_q   <= 1'b0;
      adc_addr_q  <= '0;
      adc_data_q  <= '0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      adc_wen_q   <= adc_wen_d;
      adc_addr_q  <= adc_addr_d;
      adc_data_q  <= adc_data_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  assign adc_wEn    = adc_wen_q;
  assign adc_addr   = adc_addr_q;
  assign adc_dataIn = adc_data_q;
  assign busy       = busy_q;
  assign triggered  = triggered_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 16-word frame and 4 pre-trigger samples.
module tb_adc_capture_ctrl;
  import adc_capture_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        force_trig;
  logic [11:0] trig_level;
  logic        trig_rising;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        adc_wEn;
  logic [11:0] adc_addr;
  logic [31:0] adc_dataIn;
  logic        busy;
  logic        triggered;
  logic        done;
  logic [11:0] trig_addr;
  state_e      dbg_state;

  int n_vec;
  int n_err;
  logic [11:0] exp_q[$];

  adc_capture_ctrl #(
    .ADDRESS_WIDTH(12),
    .DATA_WIDTH   (32),
    .SAMPLE_WIDTH (12),
    .FRAME_LEN    (16),
    .BASE_ADDR    (12'h800),
    .PRE_TRIG     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .adc_wEn     (adc_wEn),
    .adc_addr    (adc_addr),
    .adc_dataIn  (adc_dataIn),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done),
    .trig_addr   (trig_addr),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic v, input logic [11:0] d, input logic a, input logic f);
    @(negedge clk);
    sample_valid = v;
    sample_data  = d;
    arm          = a;
    force_trig   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    arm          = 1'b0;
    force_trig   = 1'b0;
    trig_level   = 12'd100;
    trig_rising  = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 12'd5;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({adc_wEn, adc_addr, adc_dataIn, busy, triggered, done, trig_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got wen=%b addr=%h data=%h busy=%b trig=%b done=%b taddr=%h, exp all 0",
               adc_wEn, adc_addr, adc_dataIn, busy, triggered, done, trig_addr);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'd5, 1'b0, 1'b0);
      n_vec++;
      if ({adc_wEn, busy, triggered, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_sample[%0d]: got wen=%b busy=%b trig=%b done=%b exp 0000",
                 i, adc_wEn, busy, triggered, done);
      end
    end
  endtask

  task automatic test_basic;
    logic [11:0] vals[17];
    logic [11:0] ea;
    vals = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd150, 12'd200, 12'd201, 12'd202,
             12'd203, 12'd204, 12'd205, 12'd206, 12'd207, 12'd208, 12'd209, 12'd210};
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    n_vec++;
    if ({adc_wEn, busy, triggered, done} !== 4'b0100) begin
      n_err++;
      $display("FAIL basic_arm: got wen=%b busy=%b trig=%b done=%b exp 0100",
               adc_wEn, busy, triggered, done);
    end
    for (int i = 0; i < 17; i++) exp_q.push_back(12'h800 | 12'(i % 16));
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      ea = exp_q.pop_front();
      n_vec++;
      if (adc_wEn !== 1'b1 || adc_addr !== ea || adc_dataIn !== {20'd0, vals[i]}) begin
        n_err++;
        $display("FAIL basic_write[%0d]: got wen=%b addr=%h data=%h exp 1 %h %h",
                 i, adc_wEn, adc_addr, adc_dataIn, ea, {20'd0, vals[i]});
      end
      n_vec++;
      if (triggered !== (i >= 5)) begin
        n_err++;
        $display("FAIL basic_triggered[%0d]: got %b exp %b", i, triggered, (i >= 5));
      end
      n_vec++;
      if (done !== (i == 16) || busy !== (i != 16)) begin
        n_err++;
        $display("FAIL basic_done[%0d]: got done=%b busy=%b exp %b %b", i, done, busy, (i == 16), (i != 16));
      end
    end
    n_vec++;
    if (trig_addr !== 12'h805) begin
      n_err++;
      $display("FAIL basic_trig_addr: got %h exp 805", trig_addr);
    end
    drive(1'b1, 12'd300, 1'b0, 1'b0);
    n_vec++;
    if (adc_wEn !== 1'b0 || done !== 1'b1 || dbg_state !== ST_DONE) begin
      n_err++;
      $display("FAIL basic_done_hold: got wen=%b done=%b state=%0d exp 0 1 %0d", adc_wEn, done, dbg_state, ST_DONE);
    end
  endtask

  task automatic test_wrap;
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 12'd50, 1'b0, 1'b0);
      n_vec++;
      if (adc_wEn !== 1'b1 || adc_addr !== (12'h800 | 12'(i % 16)) || busy !== 1'b1 || triggered !== 1'b0) begin
        n_err++;
        $display("FAIL wrap[%0d]: got wen=%b addr=%h busy=%b trig=%b exp 1 %h 1 0",
                 i, adc_wEn, adc_addr, busy, triggered, 12'h800 | 12'(i % 16));
      end
    end
  endtask

  task automatic test_pre_ignored;
    logic [11:0] vals[5];
    vals = '{12'd50, 12'd150, 12'd50, 12'd50, 12'd150};
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      n_vec++;
      if (triggered !== (i == 4)) begin
        n_err++;
        $display("FAIL pre_ignored_trig[%0d]: got %b exp %b", i, triggered, (i == 4));
      end
    end
    n_vec++;
    if (trig_addr !== 12'h804) begin
      n_err++;
      $display("FAIL pre_ignored_taddr: got %h exp 804", trig_addr);
    end
    for (int i = 0; i < 11; i++) drive(1'b1, 12'd150, 1'b0, 1'b0);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || adc_addr !== 12'h80F) begin
      n_err++;
      $display("FAIL pre_ignored_done: got done=%b busy=%b addr=%h exp 1 0 80f", done, busy, adc_addr);
    end
  endtask

  task automatic test_force;
    int writes;
    writes = 0;
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'd0, 1'b0, 1'b1);
      if (adc_wEn === 1'b1) writes++;
      n_vec++;
      if (triggered !== (i == 4)) begin
        n_err++;
        $display("FAIL force_trig[%0d]: got %b exp %b", i, triggered, (i == 4));
      end
    end
    n_vec++;
    if (trig_addr !== 12'h804) begin
      n_err++;
      $display("FAIL force_taddr: got %h exp 804", trig_addr);
    end
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 12'd0, 1'b0, 1'b0);
      if (adc_wEn === 1'b1) writes++;
    end
    n_vec++;
    if (writes != 16 || done !== 1'b1) begin
      n_err++;
      $display("FAIL force_writes: got writes=%0d done=%b exp 16 1", writes, done);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] vals[6];
    vals = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd150};
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 12'd200, 1'b0, 1'b0);
    drive(1'b1, 12'd77, 1'b1, 1'b0);
    n_vec++;
    if ({adc_wEn, busy, triggered, done} !== 4'b0100 || dbg_state !== ST_PRE) begin
      n_err++;
      $display("FAIL rearm_post: got wen=%b busy=%b trig=%b done=%b state=%0d exp 0100 %0d",
               adc_wEn, busy, triggered, done, dbg_state, ST_PRE);
    end
    drive(1'b1, 12'd10, 1'b0, 1'b0);
    n_vec++;
    if (adc_wEn !== 1'b1 || adc_addr !== 12'h800 || adc_dataIn !== 32'd10) begin
      n_err++;
      $display("FAIL rearm_restart: got wen=%b addr=%h data=%h exp 1 800 0000000a", adc_wEn, adc_addr, adc_dataIn);
    end
    drive(1'b1, 12'd20, 1'b0, 1'b0);
    drive(1'b1, 12'd30, 1'b0, 1'b0);
    drive(1'b1, 12'd40, 1'b0, 1'b0);
    drive(1'b1, 12'd150, 1'b0, 1'b0);
    n_vec++;
    if (triggered !== 1'b1 || trig_addr !== 12'h804) begin
      n_err++;
      $display("FAIL rearm_trigger: got trig=%b taddr=%h exp 1 804", triggered, trig_addr);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 12'd200, 1'b0, 1'b0);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_prefinal: got done=%b busy=%b exp 0 1", done, busy);
    end
    drive(1'b1, 12'd222, 1'b1, 1'b0);
    n_vec++;
    if ({adc_wEn, busy, triggered, done} !== 4'b0100) begin
      n_err++;
      $display("FAIL arm_vs_final: got wen=%b busy=%b trig=%b done=%b exp 0100", adc_wEn, busy, triggered, done);
    end
    drive(1'b1, 12'd33, 1'b0, 1'b0);
    n_vec++;
    if (adc_wEn !== 1'b1 || adc_addr !== 12'h800 || adc_dataIn !== 32'd33) begin
      n_err++;
      $display("FAIL arm_vs_final_next: got wen=%b addr=%h data=%h exp 1 800 00000021", adc_wEn, adc_addr, adc_dataIn);
    end
    drive(1'b0, 12'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_pre_ignored();
    test_force();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
